mem_responder: RTL
==================

# mem_responder

Word-addressed on-chip RAM that answers the picorv32-style memory interface driven by `pipeline`. It serves as the far end of that bus in simulation and FPGA builds. It accepts one request at a time, holds it for a programmable number of wait cycles, then completes it with a single-cycle `mem_ready` pulse. Reads return registered data; writes honour byte strobes.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `LATENCY`, 0: extra wait cycles between accept and `mem_ready`; 0..15.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `mem_valid`, in, 1: request present.
- `mem_instr`, in, 1: fetch qualifier; no behavioural effect.
- `mem_addr`, in, 32: byte address; bits [1:0] ignored.
- `mem_wdata`, in, 32: write data.
- `mem_wstrb`, in, 4: byte write enables; 0 means read.
- `mem_ready`, out, 1: one-cycle completion pulse.
- `mem_rdata`, out, 32: read data, valid while `mem_ready`=1.
- `fault`, out, 1: out-of-range access flag; pulses with `mem_ready`.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, with `mem_valid`=1: latch addr, wdata and wstrb (the accept edge).
  - Go to WAIT if `LATENCY`>0, with counter = `LATENCY`-1.
  - Otherwise go to RESP.
- WAIT: decrement the counter each cycle. At 0, go to RESP.
- RESP: `mem_ready`=1 for exactly one cycle, then return to IDLE.
- Inputs are ignored outside IDLE. Latched values are used even if the bus changes.
- Word index = (latched addr - `BASE_ADDR`) >> 2.
- In range means index < `DEPTH_WORDS`.
- Reads: `mem_rdata` is loaded with the full word on entry to RESP. Outside RESP it holds its last value.
- Writes (wstrb≠0):
  - Bytes with a set strobe bit are committed at the edge that ends RESP. Other bytes are unchanged.
  - During a write's RESP, `mem_rdata` shows the pre-write word.
- A read issued immediately after a write to the same word returns the new data.
- If `mem_valid` drops before `mem_ready`, this is a protocol violation. The request still completes normally.
- If `mem_valid` is still high in the cycle after RESP, that is a new request and is accepted from IDLE.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `fault`=0, counter 0.
- Reset mid-operation: the request is dropped, no write is committed, and `mem_ready` stays 0.
- Let cycle A be the accept cycle. `mem_ready` is high in cycle A+1+`LATENCY`.
- Back-to-back requests complete at most once every `LATENCY`+2 cycles.
- `mem_ready` is never high for two consecutive cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `MEM_RESPONDER_FAULT_EN`.
- Defined:
  - An out-of-range access raises `fault` in its RESP cycle.
  - A write is discarded and a read returns 32'h0.
  - `mem_ready` still pulses.
- Undefined:
  - `fault` is tied 0.
  - The index wraps modulo `DEPTH_WORDS`, so every address hits RAM.

## Structure
- Shared package `mem_pkg`:
  - `responder_state_t` enum (IDLE, WAIT, RESP).
  - `WORD_BYTES`=4 and the strobe width constant.
- One sub-module, `ram_bank`:
  - Single-port, byte-enable synchronous array of `DEPTH_WORDS`×32.
  - Registered read port, no reset.
- `mem_responder` holds the FSM, the latch registers, the latency counter and the range check.

## Test plan
- Reset release, `LATENCY`=0: hold `mem_ready`=0 and `mem_rdata`=0. Write 32'hDEADBEEF to 0x10 with wstrb 4'hF → `mem_ready` in cycle A+1. A following read of 0x10 returns 32'hDEADBEEF.
- Byte strobes: write 32'h11223344 to 0x20, then write 32'hAABBCCDD with wstrb 4'b0101 → a read returns 32'h11BB33DD.
- `LATENCY`=3: read 0x0 → `mem_ready` exactly in cycle A+4. Changing `mem_addr` during WAIT does not alter the returned data.
- Reset asserted in the WAIT of a write to 0x30 (prior value 32'h0) → no `mem_ready`. A read after reset returns 32'h0.
- Out of range with `DEPTH_WORDS`=1024, address 0x1000:
  - With `MEM_RESPONDER_FAULT_EN`: `fault`=1 with `mem_ready`, and a read returns 0.
  - Without it: a write to 0x1000 aliases to 0x0.
- `mem_valid` held high continuously, `LATENCY`=0 → completions spaced exactly 2 cycles apart, `mem_ready` never high on consecutive cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder bus target.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned STRB_W     = WORD_BYTES;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } responder_state_t;

endpackage

// File: rtl/ram_bank.sv
// Single-port byte-enable RAM with a registered read port; contents and read
// register are not reset.
module ram_bank
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [STRB_W-1:0] we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// picorv32-style memory target: one request at a time, programmable wait cycles,
// single-cycle mem_ready. Define MEM_RESPONDER_FAULT_EN for out-of-range faulting.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CntInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  responder_state_t  state;
  logic [3:0]        cnt;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              rdata_zero;

  logic [31:0]       cur_addr;
  logic [31:0]       offset;
  logic [AW-1:0]     word_idx;
  logic              out_of_range;
  logic              enter_resp;
  logic [STRB_W-1:0] ram_we;
  logic [31:0]       ram_rdata;
  logic              unused_bits;

  // In IDLE the RAM port follows the bus so a zero-latency read can be issued
  // on the accept edge; otherwise it follows the latched request.
  assign cur_addr = (state == StIdle) ? mem_addr : addr_q;
  assign offset   = cur_addr - BASE_ADDR;
  assign word_idx = offset[AW+1:2];

`ifdef MEM_RESPONDER_FAULT_EN
  assign out_of_range = |offset[31:AW+2];
  assign unused_bits  = ^{mem_instr, offset[1:0]};
`else
  assign out_of_range = 1'b0;
  assign unused_bits  = ^{mem_instr, offset[1:0], offset[31:AW+2]};
`endif

  assign enter_resp = ((state == StIdle) && mem_valid && (LATENCY == 0)) ||
                      ((state == StWait) && (cnt == 4'd0));

  assign ram_we = ((state == StResp) && !out_of_range) ? wstrb_q : '0;

  ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_ram_bank (
    .clk   (clk),
    .re    (enter_resp),
    .we    (ram_we),
    .addr  (word_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset, so a reset-able flag forces zero until
  // the first in-range read and for faulted reads.
  assign mem_rdata = rdata_zero ? 32'h0 : ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= '0;
      mem_ready  <= 1'b0;
      fault      <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      mem_ready <= 1'b0;
      fault     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            if (LATENCY > 0) begin
              state <= StWait;
              cnt   <= CntInit;
            end else begin
              state      <= StResp;
              mem_ready  <= 1'b1;
              fault      <= out_of_range;
              rdata_zero <= out_of_range;
            end
          end
        end
        StWait: begin
          if (cnt == 4'd0) begin
            state      <= StResp;
            mem_ready  <= 1'b1;
            fault      <= out_of_range;
            rdata_zero <= out_of_range;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StResp: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
